// File: rtl/regfile_wb_sched_if.sv
// Write-back scheduler bus: decode issue/hazard query, the two write-back
// sources (ALU, MEM) and the register file write port.
interface regfile_wb_sched_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            iss_ready;
    logic [AW-1:0]   rs1addr;
    logic [AW-1:0]   rs2addr;
    logic            rs1_use;
    logic            rs2_use;
    logic            raw_stall;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            mem_valid;
    logic [AW-1:0]   mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;
    logic            regwr;
    logic [AW-1:0]   rdaddr;
    logic [XLEN-1:0] win;

    // Pipeline side: decode plus the execute/memory write-back stages.
    modport master (
        output iss_valid, iss_rd, rs1addr, rs2addr, rs1_use, rs2_use,
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  iss_ready, raw_stall, alu_ready, mem_ready,
        input  regwr, rdaddr, win
    );

    // Scheduler side.
    modport slave (
        input  iss_valid, iss_rd, rs1addr, rs2addr, rs1_use, rs2_use,
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output iss_ready, raw_stall, alu_ready, mem_ready,
        output regwr, rdaddr, win
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and pending-register scoreboard for the 32x32
// register file. ALU and MEM results are parked in one holding slot each and
// funnelled round-robin into the single registered write port; a pend bit per
// register flags destinations issued but not yet written back.
module regfile_wb_sched #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_sched_if.slave  bus
);
    localparam int NREG = 1 << AW;

    // Holding slots (stage p0) and their valid flags.
    logic            alu_vld_p0;
    logic [AW-1:0]   alu_rd_p0;
    logic [XLEN-1:0] alu_data_p0;
    logic            mem_vld_p0;
    logic [AW-1:0]   mem_rd_p0;
    logic [XLEN-1:0] mem_data_p0;

    // rr = 0 gives the ALU priority on the next contention, 1 gives MEM.
    logic            rr;
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;

    logic            grant_alu;
    logic            grant_mem;
    logic            grant_any;
    logic [AW-1:0]   g_rd;
    logic [XLEN-1:0] g_data;
    logic            alu_acc;
    logic            mem_acc;
    logic            iss_fire;

    // Register file write port (stage p1).
    logic            regwr_p1;
    logic [AW-1:0]   rdaddr_p1;
    logic [XLEN-1:0] win_p1;

    // Round-robin grant over the held slots plus the handshake qualifiers.
    always_comb begin
        grant_alu = alu_vld_p0 && (!mem_vld_p0 || !rr);
        grant_mem = mem_vld_p0 && (!alu_vld_p0 ||  rr);
        grant_any = grant_alu || grant_mem;
        g_rd      = grant_mem ? mem_rd_p0   : alu_rd_p0;
        g_data    = grant_mem ? mem_data_p0 : alu_data_p0;
        // A slot being drained this cycle may be refilled at the same edge.
        alu_acc   = bus.alu_valid && (!alu_vld_p0 || grant_alu);
        mem_acc   = bus.mem_valid && (!mem_vld_p0 || grant_mem);
        iss_fire  = bus.iss_valid && (!pend[bus.iss_rd] || (bus.iss_rd == '0));
    end

    // Next scoreboard value: clear the granted destination, set the issued
    // one; x0 never goes pending.
    always_comb begin
        pend_nxt = pend;
        if (grant_any) begin
            pend_nxt[g_rd] = 1'b0;
        end
        if (iss_fire && (bus.iss_rd != '0)) begin
            pend_nxt[bus.iss_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Control state: slot valids, round-robin pointer, scoreboard, write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_vld_p0 <= 1'b0;
            mem_vld_p0 <= 1'b0;
            rr         <= 1'b0;
            pend       <= '0;
            regwr_p1   <= 1'b0;
            rdaddr_p1  <= '0;
            win_p1     <= '0;
        end else begin
            alu_vld_p0 <= alu_acc ? 1'b1 : (grant_alu ? 1'b0 : alu_vld_p0);
            mem_vld_p0 <= mem_acc ? 1'b1 : (grant_mem ? 1'b0 : mem_vld_p0);
            if (alu_vld_p0 && mem_vld_p0) begin
                rr <= ~rr;
            end
            pend <= pend_nxt;
            // ---- p0 -> p1: granted slot drives the register file port ----
            if (grant_any) begin
                regwr_p1  <= (g_rd != '0);
                rdaddr_p1 <= g_rd;
                win_p1    <= g_data;
            end else begin
                regwr_p1  <= 1'b0;
            end
        end
    end

    // Slot payloads load on acceptance; their valid flags qualify them.
    always_ff @(posedge clk) begin
        // ---- request -> p0: capture accepted write-back payloads ----
        if (alu_acc) begin
            alu_rd_p0   <= bus.alu_rd;
            alu_data_p0 <= bus.alu_data;
        end
        if (mem_acc) begin
            mem_rd_p0   <= bus.mem_rd;
            mem_data_p0 <= bus.mem_data;
        end
    end

    assign bus.alu_ready = !alu_vld_p0 || grant_alu;
    assign bus.mem_ready = !mem_vld_p0 || grant_mem;
    assign bus.iss_ready = !pend[bus.iss_rd] || (bus.iss_rd == '0);
    assign bus.raw_stall = (bus.rs1_use && pend[bus.rs1addr]) ||
                           (bus.rs2_use && pend[bus.rs2addr]);
    assign bus.regwr     = regwr_p1;
    assign bus.rdaddr    = rdaddr_p1;
    assign bus.win       = win_p1;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: expected register-file writes are
// queued as stimulus is driven and popped as the write port fires.
module tb_regfile_wb_sched;
    logic clk = 1'b0;
    logic rst;

    regfile_wb_sched_if #(.XLEN(32), .AW(5)) bus ();

    regfile_wb_sched #(.XLEN(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wb_t;

    wb_t         sb[$];
    logic [31:0] rf [32];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        sb.push_back('{a, d});
    endtask

    // Advance one clock; sample the write port on the falling edge, where the
    // register file model also commits.
    task automatic cyc();
        wb_t e;
        @(posedge clk);
        @(negedge clk);
        if (bus.regwr === 1'b1) begin
            chk("wb_expected", 32'(bus.regwr), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wb_addr", 32'(bus.rdaddr), 32'(e.a));
                chk("wb_data", bus.win, e.d);
                rf[bus.rdaddr] = bus.win;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst           = 1'b1;
        bus.iss_valid = 1'b1;  bus.iss_rd  = 5'd9;
        bus.rs1addr   = '0;    bus.rs2addr = '0;
        bus.rs1_use   = 1'b0;  bus.rs2_use = 1'b0;
        bus.alu_valid = 1'b1;  bus.alu_rd  = 5'd1;  bus.alu_data = 32'h1;
        bus.mem_valid = 1'b1;  bus.mem_rd  = 5'd2;  bus.mem_data = 32'h2;

        // Reset with every valid held high.
        cyc(); cyc();
        rst = 1'b0; bus.iss_valid = 1'b0; bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        chk("rst_regwr", 32'(bus.regwr), 0);
        chk("rst_rdaddr", 32'(bus.rdaddr), 0);
        chk("rst_win", bus.win, 0);
        chk("rst_alu_ready", 32'(bus.alu_ready), 1);
        chk("rst_mem_ready", 32'(bus.mem_ready), 1);
        bus.rs1_use = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.rs1addr = 5'(i);
            #1;
            chk($sformatf("rst_pend%0d", i), 32'(bus.raw_stall), 0);
        end
        bus.rs1_use = 1'b0;

        // Single ALU write: accepted edge 1, on the port after edge 2.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        #1 chk("single_alu_ready", 32'(bus.alu_ready), 1);
        push(5'd5, 32'hDEADBEEF);
        cyc();
        bus.alu_valid = 1'b0;
        chk("single_latency", 32'(bus.regwr), 0);
        cyc();
        chk("single_regwr", 32'(bus.regwr), 1);
        chk("single_rf5", rf[5], 32'hDEADBEEF);
        cyc();
        chk("single_idle", 32'(bus.regwr), 0);

        // Contention: ALU wins first, MEM waits one cycle.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h11;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 32'h22;
        push(5'd3, 32'h11); push(5'd4, 32'h22);
        cyc();
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        chk("cont1_alu_ready", 32'(bus.alu_ready), 1);
        chk("cont1_mem_ready", 32'(bus.mem_ready), 0);
        cyc(); cyc(); cyc();
        // Next contention: MEM first.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h33;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd8; bus.mem_data = 32'h44;
        push(5'd8, 32'h44); push(5'd6, 32'h33);
        cyc();
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        chk("cont2_alu_ready", 32'(bus.alu_ready), 0);
        chk("cont2_mem_ready", 32'(bus.mem_ready), 1);
        cyc(); cyc(); cyc();
        chk("cont_rf6", rf[6], 32'h33);
        chk("cont_rf8", rf[8], 32'h44);

        // RAW hazard on rd=7, cleared by a MEM write-back.
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
        #1 chk("raw_iss_ready", 32'(bus.iss_ready), 1);
        cyc();
        bus.iss_valid = 1'b0;
        bus.rs1addr = 5'd7; bus.rs1_use = 1'b1;
        #1 chk("raw_rs1_stall", 32'(bus.raw_stall), 1);
        bus.rs1_use = 1'b0;
        #1 chk("raw_rs1_unused", 32'(bus.raw_stall), 0);
        bus.rs2addr = 5'd7; bus.rs2_use = 1'b1;
        #1 chk("raw_rs2_stall", 32'(bus.raw_stall), 1);
        bus.rs2_use = 1'b0; bus.rs1_use = 1'b1;
        cyc();
        chk("raw_hold", 32'(bus.raw_stall), 1);
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h77;
        push(5'd7, 32'h77);
        cyc();
        bus.mem_valid = 1'b0;
        chk("raw_hold_accept", 32'(bus.raw_stall), 1);
        cyc();
        chk("raw_release", 32'(bus.raw_stall), 0);
        chk("raw_rf7", rf[7], 32'h77);
        bus.rs1_use = 1'b0;

        // WAW on rd=9; concurrent issue of rd=10 with the write-back grant.
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        cyc();
        #1 chk("waw_blocked", 32'(bus.iss_ready), 0);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
        push(5'd9, 32'h99);
        cyc();
        bus.alu_valid = 1'b0;
        chk("waw_still_blocked", 32'(bus.iss_ready), 0);
        bus.iss_rd = 5'd10;
        cyc();
        bus.iss_rd = 5'd9;
        #1 chk("waw_released", 32'(bus.iss_ready), 1);
        bus.iss_rd = 5'd10;
        #1 chk("set_clear_same_edge", 32'(bus.iss_ready), 0);
        bus.iss_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'hA0;
        push(5'd10, 32'hA0);
        cyc();
        bus.alu_valid = 1'b0;
        cyc();
        #1 chk("rd10_cleared", 32'(bus.iss_ready), 1);

        // Issue to x0 leaves the scoreboard untouched.
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
        #1 chk("x0_iss_ready", 32'(bus.iss_ready), 1);
        cyc();
        bus.iss_valid = 1'b0;
        bus.rs1addr = 5'd0; bus.rs1_use = 1'b1;
        #1 chk("x0_no_pend", 32'(bus.raw_stall), 0);
        bus.rs1_use = 1'b0;

        // ALU write to x0: consumes a grant, no register file write.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hABC;
        cyc();
        bus.alu_valid = 1'b0;
        cyc();
        chk("x0_regwr", 32'(bus.regwr), 0);
        chk("x0_win", bus.win, 32'hABC);

        // Reset with both slots full and rd=12 pending.
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd12;
        cyc();
        bus.iss_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd13; bus.alu_data = 32'h13;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd14; bus.mem_data = 32'h14;
        cyc();
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        bus.rs1addr = 5'd12; bus.rs1_use = 1'b1;
        #1 chk("mid_pend12", 32'(bus.raw_stall), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_regwr", 32'(bus.regwr), 0);
        chk("mid_rst_pend12", 32'(bus.raw_stall), 0);
        chk("mid_rst_alu_ready", 32'(bus.alu_ready), 1);
        chk("mid_rst_mem_ready", 32'(bus.mem_ready), 1);
        cyc();
        chk("mid_no_write", 32'(bus.regwr), 0);
        bus.rs1_use = 1'b0;

        // After reset, contention grants the ALU first again.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd15; bus.alu_data = 32'h15;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd16; bus.mem_data = 32'h16;
        push(5'd15, 32'h15); push(5'd16, 32'h16);
        cyc();
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        cyc(); cyc(); cyc();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Write-back scheduler and scoreboard for the 32x32 register file.
- Shares the register file's single write port (regwr / rdaddr / win) between two write-back sources, ALU and MEM, using round-robin arbitration.
- Tracks destination registers that are issued but not yet written, so decode can stall on RAW hazards and issue can stall on WAW hazards.
- Sits between execute/memory write-back and the register file write port; decode queries it every cycle.

Parameters:
- XLEN, 32, data width of write-back values and win.
- AW, 5, register address width; NREG = 2**AW scoreboard bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- iss_valid  in  1  decode issuing an instruction that writes iss_rd.
- iss_rd  in  AW  destination of the issuing instruction.
- iss_ready  out  1  issue may proceed (no WAW conflict).
- rs1addr  in  AW  decode source 1 address.
- rs2addr  in  AW  decode source 2 address.
- rs1_use  in  1  decode actually reads rs1.
- rs2_use  in  1  decode actually reads rs2.
- raw_stall  out  1  source operand pending; decode must hold.
- alu_valid  in  1  ALU write-back request.
- alu_rd  in  AW  ALU destination.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU request accepted when alu_valid && alu_ready.
- mem_valid  in  1  MEM write-back request.
- mem_rd  in  AW  MEM destination.
- mem_data  in  XLEN  MEM result.
- mem_ready  out  1  MEM request accepted when mem_valid && mem_ready.
- regwr  out  1  register file write enable (registered).
- rdaddr  out  AW  register file write address (registered).
- win  out  XLEN  register file write data (registered).

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst, sampled at posedge.
- Reset values:
  - pend[NREG-1:0] = 0.
  - Both holding slots empty.
  - rr = ALU-first.
  - regwr = 0, rdaddr = 0, win = 0.
  - A reset mid-operation discards held entries and pending bits; no write is issued in the cycle after reset.
- Holding slots: one slot per source holding {rd, data}.
  - x_ready = !held_x || grant_x (combinational), which allows back-to-back acceptance.
  - On accept, the slot loads at posedge.
- Arbitration: evaluated each cycle over the held slots.
  - Only one slot held: that slot is granted.
  - Both slots held: the source indicated by rr is granted, and rr flips to the other source.
  - rr is unchanged when there is no contention.
- Grant at posedge N:
  - regwr <= (rd != 0), rdaddr <= rd, win <= data.
  - The slot empties unless it is refilled at the same edge.
  - pend[rd] <= 0.
  - With no grant, regwr <= 0 and rdaddr/win hold their values.
- Latency: a request accepted at edge N is granted at earliest edge N+1. regwr is high during cycle N+1..N+2, and the register file commits at the negedge within that cycle.
- The loser of a contention waits exactly one extra cycle.
- Scoreboard:
  - iss_ready = !pend[iss_rd] || (iss_rd == 0).
  - Issue fires when iss_valid && iss_ready; then pend[iss_rd] <= 1 at posedge, but only if iss_rd != 0.
  - pend[0] is always 0.
- raw_stall = (rs1_use && pend[rs1addr]) || (rs2_use && pend[rs2addr]), combinational from registered pend.
  - raw_stall drops in the cycle following the grant edge; the negedge write precedes decode's next posedge capture.
- Simultaneous set and clear of the same bit cannot occur, because the WAW stall forces pend = 0 before an issue.
  - If a set and a clear of different bits occur at the same edge, both take effect.
- Write-back to a non-pending register is performed normally; its pend bit stays 0.
- Write-back with rd = 0 is accepted and consumes a grant slot, but drives regwr = 0.

Test Plan:
- Reset: assert rst for 2 cycles with all valids high. Required: regwr = 0, alu_ready = mem_ready = 1 after release, pend all 0, raw_stall = 0.
- Single ALU write: alu_valid with rd=5, data=0xDEADBEEF accepted at edge 1. Required: regwr=1, rdaddr=5, win=0xDEADBEEF after edge 2; register 5 reads 0xDEADBEEF by edge 3.
- Contention: ALU (rd=3, 0x11) and MEM (rd=4, 0x22) accepted at the same edge. Required: ALU granted first, MEM granted the next cycle, and the next contention grants MEM first.
- RAW: issue rd=7, then decode with rs1addr=7, rs1_use=1. Required: raw_stall=1 until the edge after MEM write-back of rd=7 is granted, then 0. With rs1_use=0, raw_stall=0 throughout.
- WAW and x0:
  - Issue rd=9 twice. Required: iss_ready=0 on the second issue until rd=9 is written back.
  - Issue rd=0. Required: iss_ready=1 and pend unchanged.
  - ALU write to rd=0. Required: regwr stays 0.
- Reset mid-operation: hold both slots full with pend[12]=1, then assert rst. Required: no write the next cycle, pend[12]=0, both readies 1.
